// File: rtl/wrr_referee.sv
// Four-to-one weighted round-robin merge of first-word-fall-through VC FIFOs
// into one downstream FIFO, with a one-cycle IDLE search between bursts.
module wrr_referee #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned WEIGHT_0   = 4,
  parameter int unsigned WEIGHT_1   = 3,
  parameter int unsigned WEIGHT_2   = 2,
  parameter int unsigned WEIGHT_3   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_0,
  input  logic                  empty_1,
  input  logic                  empty_2,
  input  logic                  empty_3,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic                  almost_full,
  output logic                  pop_0,
  output logic                  pop_1,
  output logic                  pop_2,
  output logic                  pop_3,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant,
  output logic                  idle
);

  localparam int unsigned NUM_VC = 4;
  localparam int unsigned CW     = 4;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t              state, state_d;
  logic [1:0]          ptr, ptr_d, grant_d, idx;
  logic [CW-1:0]       credit, credit_d;
  logic [NUM_VC-1:0]   empty_v, pop_v;
  logic                found;
  logic [DATA_WIDTH-1:0] data_sel;

  function automatic logic [CW-1:0] weight_of(input logic [1:0] ch);
    case (ch)
      2'd0:    return CW'(WEIGHT_0);
      2'd1:    return CW'(WEIGHT_1);
      2'd2:    return CW'(WEIGHT_2);
      default: return CW'(WEIGHT_3);
    endcase
  endfunction

  assign empty_v = {empty_3, empty_2, empty_1, empty_0};
  assign pop_0   = pop_v[0];
  assign pop_1   = pop_v[1];
  assign pop_2   = pop_v[2];
  assign pop_3   = pop_v[3];
  assign idle    = (state == IDLE);

  // Head word of the granted source
  always_comb begin
    case (grant)
      2'd0:    data_sel = data_in_0;
      2'd1:    data_sel = data_in_1;
      2'd2:    data_sel = data_in_2;
      default: data_sel = data_in_3;
    endcase
  end

  // Next-state, credit and pop generation
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    grant_d  = grant;
    credit_d = credit;
    pop_v    = '0;
    found    = 1'b0;
    idx      = ptr;
    case (state)
      IDLE: begin
        for (int k = 0; k < NUM_VC; k++) begin
          idx = ptr + 2'(k);
          if (!found && !empty_v[idx]) begin
            found    = 1'b1;
            grant_d  = idx;
            credit_d = weight_of(idx);
            state_d  = SERVE;
          end
        end
      end
      default: begin
        if (empty_v[grant]) begin
          // Source ran dry: forfeit remaining credit, move on
          state_d = IDLE;
          ptr_d   = grant + 2'd1;
        end else if (!almost_full) begin
          pop_v[grant] = ~reset;
          if (credit != '0) credit_d = credit - CW'(1);
          if (credit <= CW'(1)) begin
            state_d = IDLE;
            ptr_d   = grant + 2'd1;
          end
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      credit   <= '0;
      push     <= 1'b0;
      data_out <= '0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      grant  <= grant_d;
      credit <= credit_d;
      push   <= |pop_v;
      if (|pop_v) data_out <= data_sel;
    end
  end

endmodule

// File: tb/tb_wrr_referee.sv
// Directed bench for wrr_referee: cycle-by-cycle expected pops, idle, grant,
// push and data_out against hand-written schedules.
module tb_wrr_referee;

  logic        clk = 1'b0;
  logic        reset;
  logic        almost_full;
  logic        empty_0, empty_1, empty_2, empty_3;
  logic [11:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic        pop_0, pop_1, pop_2, pop_3;
  logic        push;
  logic [11:0] data_out;
  logic [1:0]  grant;
  logic        idle;

  int          cnt [4];
  logic [9:0]  head [4];
  logic [9:0]  exp_seq [4];
  logic        exp_push_q;
  logic [11:0] exp_data_q;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign empty_0   = (cnt[0] == 0);
  assign empty_1   = (cnt[1] == 0);
  assign empty_2   = (cnt[2] == 0);
  assign empty_3   = (cnt[3] == 0);
  assign data_in_0 = {2'd0, head[0]};
  assign data_in_1 = {2'd1, head[1]};
  assign data_in_2 = {2'd2, head[2]};
  assign data_in_3 = {2'd3, head[3]};

  wrr_referee dut (
    .clk(clk), .reset(reset),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2), .empty_3(empty_3),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .data_in_2(data_in_2), .data_in_3(data_in_3),
    .almost_full(almost_full),
    .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
    .push(push), .data_out(data_out), .grant(grant), .idle(idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic set_fifos(input int c0, input int c1, input int c2, input int c3);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    for (int i = 0; i < 4; i++) begin
      head[i]    = '0;
      exp_seq[i] = '0;
    end
  endtask

  // One cycle: ep = expected popped VC (4 = none), ei/eg = expected idle/grant (-1 = skip)
  task automatic tick(input int ep, input int ei, input int eg);
    logic [3:0] pv;
    logic [3:0] epv;
    @(negedge clk);
    pv  = {pop_3, pop_2, pop_1, pop_0};
    epv = (ep < 4) ? (4'b1 << ep) : 4'b0;
    chk("pop", 32'(pv), 32'(epv));
    if (ei >= 0) chk("idle", 32'(idle), 32'(ei));
    if (eg >= 0) chk("grant", 32'(grant), 32'(eg));
    chk("push", 32'(push), 32'(exp_push_q));
    chk("data_out", 32'(data_out), 32'(exp_data_q));
    exp_push_q = (ep < 4);
    if (ep < 4) begin
      exp_data_q  = {2'(ep), exp_seq[ep]};
      exp_seq[ep] = exp_seq[ep] + 10'd1;
    end
    if (reset) begin
      exp_push_q = 1'b0;
      exp_data_q = '0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pv[i]) begin
        cnt[i]  = cnt[i] - 1;
        head[i] = head[i] + 10'd1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(4, -1, -1);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    almost_full = 1'b0;
    exp_push_q  = 1'b0;
    exp_data_q  = '0;
    set_fifos(1000, 1000, 1000, 1000);
    @(posedge clk);
    #1;

    // Reset held with all sources non-empty
    repeat (3) tick(4, 1, 0);
    reset = 1'b0;

    // Full rotation: two 14-cycle rounds
    repeat (2) begin
      tick(4, 1, -1); repeat (4) tick(0, 0, 0);
      tick(4, 1, -1); repeat (3) tick(1, 0, 1);
      tick(4, 1, -1); repeat (2) tick(2, 0, 2);
      tick(4, 1, -1); tick(3, 0, 3);
    end

    // Backpressure after the second VC0 pop
    set_fifos(1000, 1000, 1000, 1000);
    do_reset();
    tick(4, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    almost_full = 1'b1;
    repeat (3) tick(4, 0, 0);
    almost_full = 1'b0;
    tick(0, 0, 0); tick(0, 0, 0);
    tick(4, 1, -1); tick(1, 0, 1);

    // Early empty on VC0, VC1 then gets full credit
    set_fifos(2, 1000, 0, 0);
    do_reset();
    tick(4, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    tick(4, 0, 0);
    tick(4, 1, -1);
    repeat (3) tick(1, 0, 1);
    tick(4, 1, -1); tick(1, 0, 1);

    // Single source VC2 with 5 words
    set_fifos(0, 0, 5, 0);
    do_reset();
    tick(4, 1, 0); tick(2, 0, 2); tick(2, 0, 2);
    tick(4, 1, -1); tick(2, 0, 2); tick(2, 0, 2);
    tick(4, 1, -1); tick(2, 0, 2);
    tick(4, 0, 2);
    tick(4, 1, -1); tick(4, 1, -1);

    // Reset asserted during the second VC1 pop
    set_fifos(1000, 1000, 1000, 1000);
    do_reset();
    tick(4, 1, 0); repeat (4) tick(0, 0, 0);
    tick(4, 1, -1); tick(1, 0, 1);
    reset = 1'b1;
    tick(4, 0, 1);
    reset = 1'b0;
    tick(4, 1, 0); tick(0, 0, 0); tick(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
